qam64_byte_to_symbol: RTL

Read-side consumer for the 8-bit CDC FIFO memory in the QAM-64 modulator. Runs in the read clock domain: drives the FIFO's read enable, captures the bytes the FIFO registers out, and repacks the MSB-first byte stream into 6-bit QAM-64 symbols. Symbols leave through a valid/ready handshake towards the mapper. Every 3 bytes produce exactly 4 symbols.

---
 rtl/qam64_byte_to_symbol.sv | 81 ++++++++
 1 files changed

// File: rtl/qam64_byte_to_symbol.sv
// rtl/qam64_byte_to_symbol.sv - FIFO read-side byte to 6-bit QAM-64 symbol repacker
//
// Purpose:
//   Drives the CDC FIFO read enable, captures the registered FIFO byte one
//   cycle later and repacks the MSB-first byte stream into 6-bit symbols
//   handed to the mapper over a valid/ready handshake (3 bytes -> 4 symbols).
//
// Ports:
//   read_clk    : sole clock, rising edge
//   read_rst    : asynchronous active-high reset
//   empty       : FIFO empty flag (read_clk domain)
//   fifo_data   : FIFO registered read data, valid the cycle after read_enable
//   read_enable : FIFO read request
//   sym_ready   : mapper accepts a symbol
//   sym_valid   : sym_out holds a valid symbol
//   sym_out     : symbol, bit 5 is the earliest stream bit
//   sym_count   : transferred symbol count, wraps modulo 2^SYM_CNT_W

module qam64_byte_to_symbol #(
    parameter int SYM_CNT_W = 16
) (
    input  logic                 read_clk,
    input  logic                 read_rst,
    input  logic                 empty,
    input  logic [7:0]           fifo_data,
    output logic                 read_enable,
    input  logic                 sym_ready,
    output logic                 sym_valid,
    output logic [5:0]           sym_out,
    output logic [SYM_CNT_W-1:0] sym_count
);

    logic [13:0]          bitbuf_q, bitbuf_d;
    logic [3:0]           bitcnt_q, bitcnt_d;
    logic                 pending_q, pending_d;
    logic [SYM_CNT_W-1:0] sym_count_q, sym_count_d;

    logic       capture;
    logic       transfer;
    logic [3:0] shift_amt;

    always_comb begin
        read_enable = !read_rst && !empty && !pending_q && (bitcnt_q < 4'd6);
        sym_valid   = (bitcnt_q >= 4'd6);
        capture     = pending_q;
        transfer    = sym_valid && sym_ready;

        // Oldest valid bit sits at bitbuf[bitcnt-1]; align the top 6 valid bits to [5:0].
        shift_amt = sym_valid ? (bitcnt_q - 4'd6) : 4'd0;
        sym_out   = sym_valid ? 6'(bitbuf_q >> shift_amt) : 6'd0;

        pending_d = read_enable;

        // A capture only happens with bitcnt < 6, so bitbuf[5:0] holds every valid bit.
        bitbuf_d = capture ? {bitbuf_q[5:0], fifo_data} : bitbuf_q;

        // Capture and transfer are mutually exclusive, but both terms are kept
        // so the count stays arithmetically consistent (max 5 + 8 = 13).
        bitcnt_d = bitcnt_q + (capture ? 4'd8 : 4'd0) - (transfer ? 4'd6 : 4'd0);

        sym_count_d = transfer ? (sym_count_q + {{(SYM_CNT_W-1){1'b0}}, 1'b1}) : sym_count_q;

        sym_count = sym_count_q;
    end

    // A byte in flight at reset is dropped along with pending_q.
    always_ff @(posedge read_clk or posedge read_rst) begin
        if (read_rst) begin
            bitbuf_q    <= '0;
            bitcnt_q    <= '0;
            pending_q   <= 1'b0;
            sym_count_q <= '0;
        end else begin
            bitbuf_q    <= bitbuf_d;
            bitcnt_q    <= bitcnt_d;
            pending_q   <= pending_d;
            sym_count_q <= sym_count_d;
        end
    end

endmodule
